stream_interleaver: RTL and testbench

Time-division interleaver/de-interleaver that wraps the multi-stream filter.
- Input side: round-robin serialises NR_STREAMS independent req/ack channels into the single filter input stream.
- Output side: steers filter output samples back to per-channel req/ack outputs.
- Adds what the stream-counter logic around the filter lacks: per-channel handshakes, a runtime active-channel mask with zero-fill and discard, and per-channel output buffering.
- Sits between channel sources/sinks and the filter instance.

---
 rtl/stream_interleaver_pkg.sv | 13 +
 rtl/stream_interleaver_slot_counter.sv | 29 ++
 rtl/stream_interleaver.sv | 105 ++++++++++
 tb/tb_stream_interleaver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_interleaver_pkg.sv
// Shared defaults and packed-bus helpers for the stream interleaver.
package stream_interleaver_pkg;

  localparam int DEF_DWIDTH         = 16;
  localparam int DEF_NR_STREAMS     = 13;
  localparam int DEF_NR_STREAMS_LOG = 4;

  // Low bit of channel idx within a packed NR_STREAMS*width bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/stream_interleaver_slot_counter.sv
// Channel slot counter: advances on enable, wraps from N-1 to 0, flags slot 0.
module slot_counter
  import stream_interleaver_pkg::*;
#(
  parameter int N = DEF_NR_STREAMS,
  parameter int W = DEF_NR_STREAMS_LOG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_at_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (r_count == W'(N - 1)) r_count <= '0;
      else                      r_count <= r_count + 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_at_zero = (r_count == '0);

endmodule

// File: rtl/stream_interleaver.sv
// Round-robin channel interleaver in front of the filter and per-channel
// de-interleaver with one-entry output buffers behind it.
module stream_interleaver
  import stream_interleaver_pkg::*;
#(
  parameter int DWIDTH         = DEF_DWIDTH,
  parameter int NR_STREAMS     = DEF_NR_STREAMS,
  parameter int NR_STREAMS_LOG = DEF_NR_STREAMS_LOG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_STREAMS-1:0]        active_mask,
  input  logic [NR_STREAMS-1:0]        ch_in_req,
  output logic [NR_STREAMS-1:0]        ch_in_ack,
  input  logic [NR_STREAMS*DWIDTH-1:0] ch_in_data,
  output logic                         mux_out_req,
  input  logic                         mux_out_ack,
  output logic [DWIDTH-1:0]            mux_out_data,
  input  logic                         demux_in_req,
  output logic                         demux_in_ack,
  input  logic [DWIDTH-1:0]            demux_in_data,
  output logic [NR_STREAMS-1:0]        ch_out_req,
  input  logic [NR_STREAMS-1:0]        ch_out_ack,
  output logic [NR_STREAMS*DWIDTH-1:0] ch_out_data,
  output logic [NR_STREAMS_LOG-1:0]    slot_in,
  output logic [NR_STREAMS_LOG-1:0]    slot_out
);

  logic [NR_STREAMS_LOG-1:0]    w_slot_in, w_slot_out;
  logic                         w_in_zero, w_out_zero;
  logic [NR_STREAMS-1:0]        w_mask_in, w_mask_out;
  logic                         w_in_active, w_in_load, w_out_active, w_dx;
  logic [DWIDTH-1:0]            w_in_sample;

  logic                         r_mux_req;
  logic [DWIDTH-1:0]            r_mux_data;
  logic [NR_STREAMS-1:0]        r_mask_in_q, r_mask_out_q;
  logic [NR_STREAMS-1:0]        r_full;
  logic [NR_STREAMS*DWIDTH-1:0] r_buf;

  slot_counter #(.N(NR_STREAMS), .W(NR_STREAMS_LOG)) u_slot_in (
    .clk(clk), .rst(rst), .i_en(w_in_load), .o_count(w_slot_in), .o_at_zero(w_in_zero)
  );

  slot_counter #(.N(NR_STREAMS), .W(NR_STREAMS_LOG)) u_slot_out (
    .clk(clk), .rst(rst), .i_en(w_dx), .o_count(w_slot_out), .o_at_zero(w_out_zero)
  );

  // Acks are gated by rst so every handshake output is low during reset.
  always_comb begin
    w_mask_in   = w_in_zero ? active_mask : r_mask_in_q;
    w_in_active = w_mask_in[w_slot_in];
    w_in_sample = ch_in_data[slice_lo(int'(w_slot_in), DWIDTH) +: DWIDTH];
    w_in_load   = rst && (!r_mux_req || mux_out_ack) &&
                  (!w_in_active || ch_in_req[w_slot_in]);
    ch_in_ack   = '0;
    if (w_in_load && w_in_active) ch_in_ack[w_slot_in] = 1'b1;

    w_mask_out   = w_out_zero ? active_mask : r_mask_out_q;
    w_out_active = w_mask_out[w_slot_out];
    demux_in_ack = rst && (!w_out_active || !r_full[w_slot_out] || ch_out_ack[w_slot_out]);
    w_dx         = demux_in_req && demux_in_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mux_req   <= 1'b0;
      r_mux_data  <= '0;
      r_mask_in_q <= '0;
    end else if (w_in_load) begin
      r_mux_req  <= 1'b1;
      r_mux_data <= w_in_active ? w_in_sample : '0;
      if (w_in_zero) r_mask_in_q <= active_mask;
    end else if (mux_out_ack) begin
      r_mux_req <= 1'b0;
    end
  end

  // A fill of a buffer wins over its drain in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full       <= '0;
      r_buf        <= '0;
      r_mask_out_q <= '0;
    end else begin
      for (int i = 0; i < NR_STREAMS; i++) begin
        if (w_dx && w_out_active && (int'(w_slot_out) == i)) begin
          r_full[i]                                <= 1'b1;
          r_buf[slice_lo(i, DWIDTH) +: DWIDTH]     <= demux_in_data;
        end else if (ch_out_ack[i]) begin
          r_full[i] <= 1'b0;
        end
      end
      if (w_dx && w_out_zero) r_mask_out_q <= active_mask;
    end
  end

  assign mux_out_req  = r_mux_req;
  assign mux_out_data = r_mux_data;
  assign ch_out_req   = r_full;
  assign ch_out_data  = r_buf;
  assign slot_in      = w_slot_in;
  assign slot_out     = w_slot_out;

endmodule

// File: tb/tb_stream_interleaver.sv
// Directed bench for stream_interleaver with four channels and an optional
// filter loopback from mux_out to demux_in.
module tb_stream_interleaver;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int NL = 2;

  logic             clk;
  logic             rst;
  logic [NS-1:0]    active_mask;
  logic [NS-1:0]    ch_in_req;
  logic [NS-1:0]    ch_in_ack;
  logic [NS*DW-1:0] ch_in_data;
  logic             mux_out_req;
  logic             mux_out_ack;
  logic [DW-1:0]    mux_out_data;
  logic             demux_in_req;
  logic             demux_in_ack;
  logic [DW-1:0]    demux_in_data;
  logic [NS-1:0]    ch_out_req;
  logic [NS-1:0]    ch_out_ack;
  logic [NS*DW-1:0] ch_out_data;
  logic [NL-1:0]    slot_in;
  logic [NL-1:0]    slot_out;

  logic             loop;
  logic             tb_mux_ack;

  int checks = 0;
  int errors = 0;

  stream_interleaver #(.DWIDTH(DW), .NR_STREAMS(NS), .NR_STREAMS_LOG(NL)) dut (
    .clk(clk), .rst(rst), .active_mask(active_mask),
    .ch_in_req(ch_in_req), .ch_in_ack(ch_in_ack), .ch_in_data(ch_in_data),
    .mux_out_req(mux_out_req), .mux_out_ack(mux_out_ack), .mux_out_data(mux_out_data),
    .demux_in_req(demux_in_req), .demux_in_ack(demux_in_ack), .demux_in_data(demux_in_data),
    .ch_out_req(ch_out_req), .ch_out_ack(ch_out_ack), .ch_out_data(ch_out_data),
    .slot_in(slot_in), .slot_out(slot_out)
  );

  assign mux_out_ack   = loop ? demux_in_ack : tb_mux_ack;
  assign demux_in_req  = loop ? mux_out_req  : 1'b0;
  assign demux_in_data = loop ? mux_out_data : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    loop        = 1'b0;
    tb_mux_ack  = 1'b1;
    active_mask = 4'b1111;
    ch_in_req   = 4'b1111;
    ch_out_ack  = 4'b1111;
    for (int i = 0; i < NS; i++) ch_in_data[i*DW +: DW] = 16'(16'h1000 + i);

    // Reset state
    #12;
    chk("rst_mux_req", mux_out_req, 0);
    chk("rst_mux_data", mux_out_data, 0);
    chk("rst_in_ack", ch_in_ack, 0);
    chk("rst_dmx_ack", demux_in_ack, 0);
    chk("rst_out_req", ch_out_req, 0);
    chk("rst_slots", {slot_in, slot_out}, 0);

    // 1: all channels active, continuous round robin
    rst = 1'b1;
    #1;
    chk("t1_ack_first", ch_in_ack, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t1_req", mux_out_req, 1);
      chk("t1_data", mux_out_data, 16'h1000 + (k % 4));
      chk("t1_ack", ch_in_ack, 4'b0001 << ((k + 1) % 4));
    end
    chk("t1_slot_wrap", slot_in, 0);

    // 2: mask 0101 zero-fills channels 1 and 3
    active_mask = 4'b0101;
    #1;
    chk("t2_ack_first", ch_in_ack, 4'b0001);
    for (int j = 0; j < 8; j++) begin
      step();
      chk("t2_data", mux_out_data, (j % 2) ? 0 : 16'h1000 + (j % 4));
      chk("t2_ack", ch_in_ack, ((j + 1) % 2) ? 4'b0000 : 4'b0001 << ((j + 1) % 4));
    end

    // 3: channel 2 stalls, slot_in holds, no zero inserted
    active_mask = 4'b1111;
    ch_in_req   = 4'b1011;
    step();
    chk("t3_d0", mux_out_data, 16'h1000);
    step();
    chk("t3_d1", mux_out_data, 16'h1001);
    chk("t3_slot2", slot_in, 2);
    chk("t3_ack_none", ch_in_ack, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_req_low", mux_out_req, 0);
      chk("t3_slot_hold", slot_in, 2);
    end
    ch_in_req = 4'b1111;
    #1;
    chk("t3_ack2", ch_in_ack, 4'b0100);
    step();
    chk("t3_resume_req", mux_out_req, 1);
    chk("t3_resume_data", mux_out_data, 16'h1002);
    step();
    chk("t3_d3", mux_out_data, 16'h1003);
    chk("t3_slot0", slot_in, 0);

    // 5: mask change mid-frame applies from next frame
    step();
    chk("t5_d0", mux_out_data, 16'h1000);
    step();
    chk("t5_d1", mux_out_data, 16'h1001);
    active_mask = 4'b0001;
    #1;
    chk("t5_ack2_old_mask", ch_in_ack, 4'b0100);
    step();
    chk("t5_d2", mux_out_data, 16'h1002);
    step();
    chk("t5_d3", mux_out_data, 16'h1003);
    chk("t5_ack0", ch_in_ack, 4'b0001);
    step();
    chk("t5_n0", mux_out_data, 16'h1000);
    chk("t5_ack1_none", ch_in_ack, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_zero_req", mux_out_req, 1);
      chk("t5_zero_data", mux_out_data, 0);
    end

    // 4: loopback, mask 1011, sinks 0 and 3 stalled
    rst         = 1'b0;
    loop        = 1'b1;
    active_mask = 4'b1011;
    ch_out_ack  = 4'b0110;
    #2;
    rst = 1'b1;
    #1;
    chk("t4_ack_first", ch_in_ack, 4'b0001);
    chk("t4_dmx_ack_first", demux_in_ack, 1);
    step();
    chk("t4_e1_data", mux_out_data, 16'h1000);
    chk("t4_e1_ack", ch_in_ack, 4'b0010);
    chk("t4_e1_oreq", ch_out_req, 0);
    step();
    chk("t4_e2_oreq", ch_out_req, 4'b0001);
    chk("t4_e2_odata0", ch_out_data[15:0], 16'h1000);
    chk("t4_e2_data", mux_out_data, 16'h1001);
    chk("t4_e2_slot_out", slot_out, 1);
    chk("t4_e2_ack", ch_in_ack, 0);
    step();
    chk("t4_e3_oreq", ch_out_req, 4'b0011);
    chk("t4_e3_data", mux_out_data, 0);
    chk("t4_e3_dmx_ack", demux_in_ack, 1);
    chk("t4_e3_ack", ch_in_ack, 4'b1000);
    step();
    chk("t4_e4_oreq", ch_out_req, 4'b0001);
    chk("t4_e4_slot_out", slot_out, 3);
    chk("t4_e4_data", mux_out_data, 16'h1003);
    step();
    chk("t4_e5_oreq", ch_out_req, 4'b1001);
    chk("t4_e5_odata3", ch_out_data[63:48], 16'h1003);
    chk("t4_e5_dmx_ack", demux_in_ack, 0);
    chk("t4_e5_ack", ch_in_ack, 0);
    step();
    chk("t4_e6_oreq", ch_out_req, 4'b1001);
    chk("t4_e6_odata0", ch_out_data[15:0], 16'h1000);
    chk("t4_e6_slots", {slot_in, slot_out}, 4'b0100);
    chk("t4_e6_mux", {mux_out_req, mux_out_data}, 17'h11000);

    // 6: asynchronous reset mid-transfer
    rst = 1'b0;
    #1;
    chk("t6_mux_req", mux_out_req, 0);
    chk("t6_mux_data", mux_out_data, 0);
    chk("t6_in_ack", ch_in_ack, 0);
    chk("t6_dmx_ack", demux_in_ack, 0);
    chk("t6_out_req", ch_out_req, 0);
    chk("t6_slots", {slot_in, slot_out}, 0);
    ch_out_ack = 4'b1111;
    rst = 1'b1;
    #1;
    chk("t6_ack_first", ch_in_ack, 4'b0001);
    step();
    chk("t6_first_data", mux_out_data, 16'h1000);
    chk("t6_slot_in", slot_in, 1);
    step();
    chk("t6_oreq", ch_out_req, 4'b0001);
    chk("t6_odata0", ch_out_data[15:0], 16'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
